shift_seq: RTL

Multi-cycle sequencer wrapped around the 8-bit combinational barrel shifter (3-bit shift amount, left/right, arithmetic/logical). It accepts one shift command with a 5-bit amount (0..31) over a valid/ready handshake. It sends the operand through the shifter in successive passes of at most 7 positions, feeding each result back, and presents the final result on a valid/ready output. It is both the upstream stage that drives the shifter and the downstream stage that consumes its output.

---
 rtl/shift_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// shift_seq: sequencer that walks an operand through an external 8-bit barrel shifter in passes of up to 7.
// Build option SHIFT_SEQ_SATURATE_EN: amounts >= 8 collapse to a single saturating pass.
module shift_seq #(
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [2:0]       out_passes,
  output logic [7:0]       sh_din,
  output logic [2:0]       sh_shamt,
  output logic             sh_lr,
  output logic             sh_al,
  input  logic [7:0]       sh_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       acc_r, acc_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic             dir_r, dir_s;
  logic             arith_r, arith_s;
  logic [2:0]       passes_r, passes_s;
  logic [2:0]       step_s;
  logic [AMT_W-1:0] rem_left_s;
  logic             sat_s;
  logic [7:0]       fill_s;

  // Per-pass amount, remainder after this pass, and saturation decision.
  always_comb begin
    step_s     = (rem_r > AMT_W'(7)) ? 3'd7 : rem_r[2:0];
    rem_left_s = rem_r - AMT_W'(step_s);
    fill_s     = (!dir_r && arith_r) ? {8{acc_r[7]}} : 8'h00;
`ifdef SHIFT_SEQ_SATURATE_EN
    sat_s      = (rem_r > AMT_W'(7));
`else
    sat_s      = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    rem_s    = rem_r;
    dir_s    = dir_r;
    arith_s  = arith_r;
    passes_s = passes_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          acc_s    = in_data;
          rem_s    = in_amt;
          dir_s    = in_dir;
          arith_s  = in_arith;
          passes_s = 3'd0;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (sat_s) begin
          acc_s    = fill_s;
          rem_s    = {AMT_W{1'b0}};
          passes_s = 3'd1;
          state_s  = DONE;
        end else begin
          acc_s    = sh_dout;
          rem_s    = rem_left_s;
          passes_s = passes_r + 3'd1;
          if (rem_left_s == {AMT_W{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath registers: accumulator, remaining amount, command attributes, pass count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= 8'h00;
      rem_r    <= {AMT_W{1'b0}};
      dir_r    <= 1'b0;
      arith_r  <= 1'b0;
      passes_r <= 3'd0;
    end else begin
      acc_r    <= acc_s;
      rem_r    <= rem_s;
      dir_r    <= dir_s;
      arith_r  <= arith_s;
      passes_r <= passes_s;
    end
  end

  // Outputs decoded purely from registered state; the shifter only sees a nonzero amount in RUN.
  always_comb begin
    in_ready   = (state_r == IDLE);
    out_valid  = (state_r == DONE);
    out_data   = acc_r;
    out_passes = passes_r;
    sh_din     = acc_r;
    sh_lr      = dir_r;
    sh_al      = arith_r;
    if ((state_r == RUN) && !sat_s) begin
      sh_shamt = step_s;
    end else begin
      sh_shamt = 3'd0;
    end
  end

endmodule
